sf_tester_iter_ctrl: RTL and testbench



---
 rtl/sf_tester_fsm_pkg.sv | 30 +++
 rtl/sf_pattern_gen.sv | 23 ++
 rtl/sf_tester_iter_ctrl.sv | 152 +++++++++++++++
 tb/tb_sf_tester_iter_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sf_tester_fsm_pkg.sv
// Shared tester constants, iteration-controller state encoding and pattern helpers.
package sf_tester_fsm_pkg;

  localparam int          c_tester_subsector_cnt_per_iter = 256;
  localparam int          c_tester_page_cnt_per_iter      = 4096;
  localparam logic [31:0] c_per_iteration_byte_count      = 32'h0010_0000;
  localparam logic [31:0] c_subsector_byte_count          = 32'h0000_1000;
  localparam logic [31:0] c_page_byte_count               = 32'h0000_0100;

  localparam logic [1:0] c_phase_idle  = 2'd0;
  localparam logic [1:0] c_phase_erase = 2'd1;
  localparam logic [1:0] c_phase_prog  = 2'd2;
  localparam logic [1:0] c_phase_read  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ERASE_START, ST_ERASE_WAIT, ST_ERASE_NEXT,
    ST_PAGE_FILL, ST_PAGE_START, ST_PAGE_WAIT, ST_PAGE_NEXT,
    ST_READ_START, ST_READ_WAIT, ST_READ_NEXT, ST_DONE
  } t_iter_ctrl_state;

  // Patterns A..D start at 00/08/10/18 and step by 01/07/0F/17.
  function automatic logic [7:0] pat_start(input logic [1:0] sel);
    return {2'b00, sel, 3'b000} << 1 >> 1;
  endfunction

  function automatic logic [7:0] pat_incr(input logic [1:0] sel);
    return (sel == 2'd0) ? 8'h01 : (pat_start(sel) - 8'h01);
  endfunction

endpackage

// File: rtl/sf_pattern_gen.sv
// Expected/transmit byte generator: start + n*incr mod 256, restarted by load.
module sf_pattern_gen
  import sf_tester_fsm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] sel_i,
  input  logic       load_i,
  input  logic       advance_i,
  output logic [7:0] data_o
);

  logic [7:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          data_q <= 8'h00;
    else if (load_i)    data_q <= pat_start(sel_i);
    else if (advance_i) data_q <= data_q + pat_incr(sel_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/sf_tester_iter_ctrl.sv
// One tester iteration: erase a block, program it with a pattern, read back and count mismatches.
module sf_tester_iter_ctrl
  import sf_tester_fsm_pkg::*;
#(
  parameter int SUBSECTOR_CNT = c_tester_subsector_cnt_per_iter,
  parameter int PAGE_CNT      = c_tester_page_cnt_per_iter,
  parameter int PAGE_BYTES    = 256
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz,
  input  logic        i_start,
  input  logic [4:0]  i_iter,
  input  logic [1:0]  i_pattern_sel,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_phase,
  output logic [31:0] o_err_count,
  output logic        o_cmd_erase,
  output logic        o_cmd_page_prog,
  output logic        o_cmd_read,
  output logic [31:0] o_cmd_addr,
  output logic [8:0]  o_cmd_len,
  input  logic        i_cmd_ready,
  input  logic        i_cmd_done,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid
);

  t_iter_ctrl_state state_q;
  logic [4:0]  iter_q;
  logic [1:0]  pat_q;
  logic [15:0] sub_q, page_q;
  logic [8:0]  byte_q;
  logic        busy_q, done_q, erase_q, prog_q, read_q, tx_valid_q;
  logic [1:0]  phase_q;
  logic [31:0] err_q, addr_q, base;
  logic [8:0]  len_q;
  logic [7:0]  pat_data;
  logic        sub_last, page_last, byte_last, pat_load, pat_adv;

  assign base      = {27'd0, iter_q} * c_per_iteration_byte_count;
  assign sub_last  = (sub_q == 16'(SUBSECTOR_CNT - 1));
  assign page_last = (page_q == 16'(PAGE_CNT - 1));
  assign byte_last = (byte_q == 9'(PAGE_BYTES - 1));

  // Generator restarts at the start of the program and read phases; the byte
  // index runs across page boundaries within a phase.
  assign pat_load = (state_q == ST_ERASE_NEXT && sub_last) ||
                    (state_q == ST_PAGE_NEXT && page_last);
  assign pat_adv  = (state_q == ST_PAGE_FILL && tx_valid_q && i_tx_ready) ||
                    (state_q == ST_READ_WAIT && i_rx_valid);

  sf_pattern_gen u_pat (
    .clk_i     (i_clk_20mhz),
    .rst_i     (i_rst_20mhz),
    .sel_i     (pat_q),
    .load_i    (pat_load),
    .advance_i (pat_adv),
    .data_o    (pat_data)
  );

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= ST_IDLE;
      iter_q <= '0; pat_q <= '0; sub_q <= '0; page_q <= '0; byte_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; phase_q <= c_phase_idle; err_q <= '0;
      erase_q <= 1'b0; prog_q <= 1'b0; read_q <= 1'b0;
      addr_q <= '0; len_q <= '0; tx_valid_q <= 1'b0;
    end else begin
      erase_q <= 1'b0;
      prog_q  <= 1'b0;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (i_start) begin
          iter_q <= i_iter; pat_q <= i_pattern_sel; err_q <= '0;
          sub_q <= '0; page_q <= '0; byte_q <= '0;
          busy_q <= 1'b1; phase_q <= c_phase_erase;
          state_q <= ST_ERASE_START;
        end
        ST_ERASE_START: if (i_cmd_ready) begin
          erase_q <= 1'b1;
          addr_q  <= base + {16'd0, sub_q} * c_subsector_byte_count;
          state_q <= ST_ERASE_WAIT;
        end
        ST_ERASE_WAIT: if (i_cmd_done) state_q <= ST_ERASE_NEXT;
        ST_ERASE_NEXT: if (sub_last) begin
          phase_q <= c_phase_prog; page_q <= '0; byte_q <= '0;
          tx_valid_q <= 1'b1; state_q <= ST_PAGE_FILL;
        end else begin
          sub_q <= sub_q + 16'd1; state_q <= ST_ERASE_START;
        end
        ST_PAGE_FILL: if (tx_valid_q && i_tx_ready) begin
          byte_q <= byte_q + 9'd1;
          if (byte_last) begin
            tx_valid_q <= 1'b0; state_q <= ST_PAGE_START;
          end
        end
        ST_PAGE_START: if (i_cmd_ready) begin
          prog_q  <= 1'b1;
          addr_q  <= base + {16'd0, page_q} * c_page_byte_count;
          len_q   <= 9'(PAGE_BYTES);
          state_q <= ST_PAGE_WAIT;
        end
        ST_PAGE_WAIT: if (i_cmd_done) state_q <= ST_PAGE_NEXT;
        ST_PAGE_NEXT: if (page_last) begin
          page_q <= '0; phase_q <= c_phase_read; state_q <= ST_READ_START;
        end else begin
          page_q <= page_q + 16'd1; byte_q <= '0;
          tx_valid_q <= 1'b1; state_q <= ST_PAGE_FILL;
        end
        ST_READ_START: if (i_cmd_ready) begin
          read_q  <= 1'b1;
          addr_q  <= base + {16'd0, page_q} * c_page_byte_count;
          len_q   <= 9'(PAGE_BYTES);
          state_q <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          // A byte arriving with the done pulse is still compared.
          if (i_rx_valid && (i_rx_data != pat_data) && (err_q != 32'hFFFF_FFFF))
            err_q <= err_q + 32'd1;
          if (i_cmd_done) state_q <= ST_READ_NEXT;
        end
        ST_READ_NEXT: if (page_last) state_q <= ST_DONE;
        else begin
          page_q <= page_q + 16'd1; state_q <= ST_READ_START;
        end
        ST_DONE: begin
          done_q <= 1'b1; busy_q <= 1'b0; phase_q <= c_phase_idle;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_phase         = phase_q;
  assign o_err_count     = err_q;
  assign o_cmd_erase     = erase_q;
  assign o_cmd_page_prog = prog_q;
  assign o_cmd_read      = read_q;
  assign o_cmd_addr      = addr_q;
  assign o_cmd_len       = len_q;
  assign o_tx_data       = pat_data;
  assign o_tx_valid      = tx_valid_q;

endmodule

// File: tb/tb_sf_tester_iter_ctrl.sv
// Scoreboard bench: expected commands/tx bytes/err counts queued at start, checked against a driver/flash model.
module tb_sf_tester_iter_ctrl;

  localparam int SUB = 2, PG = 2, PB = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic i_start = 1'b0, i_cmd_ready = 1'b0, i_cmd_done = 1'b0;
  logic i_tx_ready = 1'b0, i_rx_valid = 1'b0;
  logic [4:0] i_iter = '0;
  logic [1:0] i_pattern_sel = '0;
  logic [7:0] i_rx_data = '0;
  logic o_busy, o_done, o_cmd_erase, o_cmd_page_prog, o_cmd_read, o_tx_valid;
  logic [1:0] o_phase;
  logic [31:0] o_err_count, o_cmd_addr;
  logic [8:0] o_cmd_len;
  logic [7:0] o_tx_data;

  always #25 clk = ~clk;

  sf_tester_iter_ctrl #(.SUBSECTOR_CNT(SUB), .PAGE_CNT(PG), .PAGE_BYTES(PB)) dut (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_start(i_start), .i_iter(i_iter),
    .i_pattern_sel(i_pattern_sel), .o_busy(o_busy), .o_done(o_done), .o_phase(o_phase),
    .o_err_count(o_err_count), .o_cmd_erase(o_cmd_erase), .o_cmd_page_prog(o_cmd_page_prog),
    .o_cmd_read(o_cmd_read), .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len),
    .i_cmd_ready(i_cmd_ready), .i_cmd_done(i_cmd_done), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid)
  );

  typedef struct { logic [2:0] kind; logic [31:0] addr; } cmd_t;
  cmd_t        exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_err_q[$];
  logic [7:0]  mem [logic [31:0]];
  logic [7:0]  fill_buf[$];

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Driver / flash model state
  logic drv_busy = 1'b0, drv_rd = 1'b0, prev_ready = 1'b0, tx_hold = 1'b0;
  logic tx_toggle = 1'b0, rdy_block = 1'b0;
  logic [31:0] drv_addr = '0;
  logic [7:0] tx_hold_d = '0;
  int drv_cnt = 0, drv_idx = 0, corrupt_left = 0;

  always @(negedge clk) begin
    cmd_t e;
    logic [7:0] b;
    logic [31:0] a;
    i_cmd_done = 1'b0;
    i_rx_valid = 1'b0;
    if (rst) begin
      drv_busy = 1'b0; tx_hold = 1'b0; fill_buf.delete();
      i_cmd_ready = 1'b0; prev_ready = 1'b0;
    end else begin
      if (o_cmd_erase || o_cmd_page_prog || o_cmd_read) begin
        chk("ready_at_issue", {31'd0, prev_ready}, 32'd1);
        if (exp_cmd_q.size() == 0) chk("extra_cmd", 32'd1, 32'd0);
        else begin
          e = exp_cmd_q.pop_front();
          chk("cmd_kind", {29'd0, o_cmd_read, o_cmd_page_prog, o_cmd_erase}, {29'd0, e.kind});
          chk("cmd_addr", o_cmd_addr, e.addr);
        end
        if (!o_cmd_erase) chk("cmd_len", {23'd0, o_cmd_len}, PB);
        if (o_cmd_page_prog) begin
          foreach (fill_buf[i]) mem[o_cmd_addr + 32'(i)] = fill_buf[i];
          fill_buf.delete();
        end
        drv_busy = 1'b1; drv_rd = o_cmd_read; drv_addr = o_cmd_addr; drv_idx = 0; drv_cnt = 3;
      end else if (drv_busy) begin
        if (drv_rd) begin
          a = drv_addr + 32'(drv_idx);
          b = mem.exists(a) ? mem[a] : 8'hFF;
          if (corrupt_left > 0) begin b = b ^ 8'h5A; corrupt_left--; end
          i_rx_valid = 1'b1; i_rx_data = b; drv_idx++;
          if (drv_idx == PB) begin i_cmd_done = 1'b1; drv_busy = 1'b0; end
        end else begin
          drv_cnt--;
          if (drv_cnt == 0) begin i_cmd_done = 1'b1; drv_busy = 1'b0; end
        end
      end
      // tx_ready set now is what the DUT samples on the coming edge
      i_tx_ready = tx_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_tx_valid) begin
        if (tx_hold) chk("tx_stable", {24'd0, o_tx_data}, {24'd0, tx_hold_d});
        if (i_tx_ready) begin
          if (exp_tx_q.size() == 0) chk("extra_tx", 32'd1, 32'd0);
          else chk("tx_data", {24'd0, o_tx_data}, {24'd0, exp_tx_q.pop_front()});
          fill_buf.push_back(o_tx_data);
          tx_hold = 1'b0;
        end else begin
          tx_hold = 1'b1; tx_hold_d = o_tx_data;
        end
      end else tx_hold = 1'b0;
      i_cmd_ready = !drv_busy && !rdy_block;
      prev_ready = i_cmd_ready;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    chk({tag, "_phase"}, {30'd0, o_phase}, 32'd0);
    chk({tag, "_err"},   o_err_count, 32'd0);
    chk({tag, "_cmds"},  {29'd0, o_cmd_erase, o_cmd_page_prog, o_cmd_read}, 32'd0);
    chk({tag, "_txv"},   {31'd0, o_tx_valid}, 32'd0);
  endtask

  task automatic run_iter(input int iter, input int pat, input int corrupt, input bit toggle,
                          input bit blk, input bit xstart, input bit rst_mid);
    logic [31:0] base;
    logic [7:0] st, inc, v;
    int cyc, blk_cnt, rd_cyc;
    bit xs_done, xs_chk, got_done;
    base = 32'(iter) * 32'h0010_0000;
    st  = 8'(pat * 8);
    inc = (pat == 0) ? 8'h01 : 8'(pat * 8 - 1);
    for (int k = 0; k < SUB; k++) exp_cmd_q.push_back('{3'b001, base + 32'(k) * 32'h1000});
    for (int p = 0; p < PG; p++)  exp_cmd_q.push_back('{3'b010, base + 32'(p) * 32'h100});
    for (int p = 0; p < PG; p++)  exp_cmd_q.push_back('{3'b100, base + 32'(p) * 32'h100});
    v = st;
    for (int n = 0; n < PG * PB; n++) begin exp_tx_q.push_back(v); v = v + inc; end
    exp_err_q.push_back(32'(corrupt));
    mem.delete();
    corrupt_left = corrupt; tx_toggle = toggle;
    i_iter = 5'(iter); i_pattern_sel = 2'(pat); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    chk("phase_after_start", {30'd0, o_phase}, 32'd1);
    blk_cnt = 0; rd_cyc = 0; xs_done = 0; xs_chk = 0; got_done = 0;
    for (cyc = 0; cyc < 5000 && !got_done; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (xs_chk) begin
        chk("xstart_busy", {31'd0, o_busy}, 32'd1);
        chk("xstart_phase", {30'd0, o_phase}, 32'd2);
        xs_chk = 0;
        i_iter = 5'(iter); i_pattern_sel = 2'(pat);
      end
      if (xstart && !xs_done && o_phase == 2'd2) begin
        i_start = 1'b1; i_iter = 5'd0; i_pattern_sel = 2'd3; xs_done = 1; xs_chk = 1;
      end
      if (blk && blk_cnt < 10 && o_phase == 2'd2) begin rdy_block = 1'b1; blk_cnt++; end
      else rdy_block = 1'b0;
      if (rst_mid && o_phase == 2'd3 && ++rd_cyc == 4) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        exp_cmd_q.delete(); exp_tx_q.delete(); exp_err_q.delete(); corrupt_left = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (o_done) begin
        got_done = 1;
        chk("err_count", o_err_count, exp_err_q.size() ? exp_err_q.pop_front() : 32'hDEAD);
        chk("busy_at_done", {31'd0, o_busy}, 32'd0);
        chk("phase_at_done", {30'd0, o_phase}, 32'd0);
        chk("cmds_left", 32'(exp_cmd_q.size()), 32'd0);
        chk("tx_left", 32'(exp_tx_q.size()), 32'd0);
      end
    end
    if (!got_done) begin
      chk("done_timeout", 32'd0, 32'd1);
      exp_cmd_q.delete(); exp_tx_q.delete(); exp_err_q.delete();
    end
    tx_toggle = 1'b0; rdy_block = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_len", {23'd0, o_cmd_len}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_iter(3, 0, 0, 0, 0, 0, 0);   // pattern A
    run_iter(3, 3, 0, 0, 0, 0, 0);   // pattern D: 18,2F,46,...
    run_iter(3, 0, 3, 0, 0, 0, 0);   // three corrupted read bytes
    run_iter(3, 1, 0, 1, 1, 0, 0);   // tx backpressure, cmd_ready held low
    run_iter(5, 2, 0, 0, 0, 1, 0);   // ignored start during program phase
    run_iter(3, 0, 0, 0, 0, 0, 1);   // reset mid-read
    run_iter(3, 0, 0, 0, 0, 0, 0);   // restart after reset
    run_iter(31, 1, 0, 0, 0, 0, 0);  // top iteration, base 0x01F00000
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
